cpx_integrate_dump: RTL and testbench

// - Coherent integrate-and-dump for complex products; sits directly downstream of the complex multiplier.
// - Sums acc_len accepted I/Q product samples per frame.
// - Emits one complex sum with a one-cycle valid pulse per frame; feeds the CAF magnitude/peak stage.

---
 rtl/cpx_integrate_dump_pkg.sv | 19 +
 rtl/cpx_integrate_dump_lane.sv | 67 ++++++
 rtl/cpx_integrate_dump.sv | 133 +++++++++++++
 tb/tb_cpx_integrate_dump.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpx_integrate_dump_pkg.sv
// Shared definitions for the complex integrate-and-dump block: FSM state
// encoding and a constant clog2 helper for sizing the sample counter.
package cpx_integrate_dump_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((64'd1 << k) < 64'(v)) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cpx_integrate_dump_lane.sv
// One accumulator lane (instantiated for I and for Q). With CPX_ACC_SAT_EN
// defined the lane saturates and tracks a sticky overflow flag; otherwise it wraps.
module cpx_acc_lane #(
  parameter int unsigned acc_bits = 34
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clr,
  input  logic                       i_add,
  input  logic                       i_flush,
  input  logic signed [acc_bits-1:0] i_x,
  output logic signed [acc_bits-1:0] o_acc_nxt,
  output logic                       o_ovf_nxt
);

  logic signed [acc_bits-1:0] r_acc;
  logic signed [acc_bits-1:0] w_base;
  logic signed [acc_bits-1:0] w_addend;

`ifdef CPX_ACC_SAT_EN
  logic                       r_ovf;
  logic signed [acc_bits:0]   w_sum;
  logic                       w_over;

  always_comb begin
    w_base    = i_clr ? '0 : r_acc;
    w_addend  = i_add ? i_x : '0;
    w_sum     = {w_base[acc_bits-1], w_base} + {w_addend[acc_bits-1], w_addend};
    w_over    = w_sum[acc_bits] ^ w_sum[acc_bits-1];
    o_acc_nxt = w_sum[acc_bits-1:0];
    if (w_over) begin
      o_acc_nxt = w_sum[acc_bits] ? {1'b1, {(acc_bits-1){1'b0}}}
                                  : {1'b0, {(acc_bits-1){1'b1}}};
    end
    o_ovf_nxt = (~i_clr & r_ovf) | w_over;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (i_flush) begin
      r_ovf <= 1'b0;
    end else if (i_clr | i_add) begin
      r_ovf <= o_ovf_nxt;
    end
  end
`else
  always_comb begin
    w_base    = i_clr ? '0 : r_acc;
    w_addend  = i_add ? i_x : '0;
    o_acc_nxt = w_base + w_addend;
    o_ovf_nxt = 1'b0;
  end
`endif

  // The dump consumes o_acc_nxt directly, so the lane itself is zeroed on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_flush) begin
      r_acc <= '0;
    end else if (i_clr | i_add) begin
      r_acc <= o_acc_nxt;
    end
  end

endmodule

// File: rtl/cpx_integrate_dump.sv
// Coherent complex integrate-and-dump: sums acc_len accepted I/Q samples per frame
// and pulses s_axis_acc_tvalid with the sums. CPX_ACC_SAT_EN selects saturation + ovf.
module cpx_integrate_dump
  import cpx_integrate_dump_pkg::*;
#(
  parameter int unsigned i_bits   = 24,
  parameter int unsigned q_bits   = 24,
  parameter int unsigned acc_len  = 1024,
  parameter int unsigned acc_bits = 34
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       m_axis_i_tvalid,
  input  logic signed [i_bits-1:0]   i,
  input  logic                       m_axis_q_tvalid,
  input  logic signed [q_bits-1:0]   q,
  output logic                       s_axis_acc_tvalid,
  output logic signed [acc_bits-1:0] acc_i,
  output logic signed [acc_bits-1:0] acc_q,
  output logic                       busy,
  output logic                       ovf
);

  localparam int unsigned CNT_W = clog2(acc_len + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(acc_len - 1);

  state_t                     r_state, w_state_nxt;
  logic [CNT_W-1:0]           r_count, w_count_nxt;
  logic                       w_accept, w_last, w_frame_start;
  logic                       w_clr, w_add, w_dump;

  logic signed [acc_bits-1:0] w_x_i, w_x_q;
  logic signed [acc_bits-1:0] w_nxt_i, w_nxt_q;
  logic                       w_ovf_i, w_ovf_q;

  logic                       r_tvalid;
  logic signed [acc_bits-1:0] r_acc_i, r_acc_q;
  logic                       r_ovf;

  assign w_x_i = acc_bits'(i);
  assign w_x_q = acc_bits'(q);

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_clr         = 1'b0;
    w_add         = 1'b0;
    w_dump        = 1'b0;
    w_accept      = m_axis_i_tvalid & m_axis_q_tvalid & ((r_state == ACCUM) | start);
    w_last        = (r_state == ACCUM) & w_accept & (r_count == LAST_CNT);
    // start on the closing sample completes that frame and opens an empty one
    w_frame_start = start & ~w_last;

    case (r_state)
      IDLE, ACCUM: begin
        if (w_last) begin
          w_add       = 1'b1;
          w_dump      = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = start ? ACCUM : IDLE;
        end else if (w_frame_start) begin
          w_clr       = 1'b1;
          w_add       = w_accept;
          w_count_nxt = w_accept ? CNT_W'(1) : '0;
          w_state_nxt = ACCUM;
        end else if (w_accept) begin
          w_add       = 1'b1;
          w_count_nxt = r_count + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  cpx_acc_lane #(.acc_bits(acc_bits)) u_lane_i (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_add     (w_add),
    .i_flush   (w_dump),
    .i_x       (w_x_i),
    .o_acc_nxt (w_nxt_i),
    .o_ovf_nxt (w_ovf_i)
  );

  cpx_acc_lane #(.acc_bits(acc_bits)) u_lane_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_add     (w_add),
    .i_flush   (w_dump),
    .i_x       (w_x_q),
    .o_acc_nxt (w_nxt_q),
    .o_ovf_nxt (w_ovf_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tvalid <= 1'b0;
      r_acc_i  <= '0;
      r_acc_q  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_tvalid <= w_dump;
      if (w_dump) begin
        r_acc_i <= w_nxt_i;
        r_acc_q <= w_nxt_q;
        r_ovf   <= w_ovf_i | w_ovf_q;
      end
    end
  end

  assign s_axis_acc_tvalid = r_tvalid;
  assign acc_i             = r_acc_i;
  assign acc_q             = r_acc_q;
  assign ovf               = r_ovf;
  assign busy              = (r_state == ACCUM);

endmodule

// File: tb/tb_cpx_integrate_dump.sv
// Self-checking bench for cpx_integrate_dump: directed literal cases plus
// randomized traffic compared every cycle against a frame-level reference model.
module tb_cpx_integrate_dump;

  localparam int IB   = 8;
  localparam int QB   = 8;
  localparam int LEN  = 4;
  localparam int AB   = 8;
  localparam int AMAX = (1 << (AB - 1)) - 1;
  localparam int AMIN = -(1 << (AB - 1));

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 start = 1'b0;
  logic                 vi    = 1'b0;
  logic                 vq    = 1'b0;
  logic signed [IB-1:0] di    = '0;
  logic signed [QB-1:0] dq    = '0;
  logic                 tv, busy, ovf;
  logic signed [AB-1:0] acc_i, acc_q;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cpx_integrate_dump #(
    .i_bits   (IB),
    .q_bits   (QB),
    .acc_len  (LEN),
    .acc_bits (AB)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .m_axis_i_tvalid   (vi),
    .i                 (di),
    .m_axis_q_tvalid   (vq),
    .q                 (dq),
    .s_axis_acc_tvalid (tv),
    .acc_i             (acc_i),
    .acc_q             (acc_q),
    .busy              (busy),
    .ovf               (ovf)
  );

  // Reference model: frame bookkeeping with integer sums.
  bit m_active = 0;
  int m_cnt = 0, m_si = 0, m_sq = 0;
  bit m_ov = 0;
  bit e_tv = 0;
  int e_ai = 0, e_aq = 0;
  bit e_ovf = 0;

  function automatic int lane_add(int a, int x);
    int s;
    s = a + x;
`ifdef CPX_ACC_SAT_EN
    if (s > AMAX) begin s = AMAX; m_ov = 1'b1; end
    else if (s < AMIN) begin s = AMIN; m_ov = 1'b1; end
`else
    s = s & ((1 << AB) - 1);
    if (s > AMAX) s = s - (1 << AB);
`endif
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_cnt = 0; m_si = 0; m_sq = 0; m_ov = 0;
      e_tv = 0; e_ai = 0; e_aq = 0; e_ovf = 0;
    end else begin : model_step
      bit acc;
      acc  = vi && vq && (m_active || start);
      e_tv = 0;
      if (m_active && acc && m_cnt == LEN - 1) begin
        e_ai  = lane_add(m_si, int'(di));
        e_aq  = lane_add(m_sq, int'(dq));
        e_ovf = m_ov;
        e_tv  = 1;
        m_active = start;
        m_cnt = 0; m_si = 0; m_sq = 0; m_ov = 0;
      end else if (start) begin
        m_active = 1;
        m_cnt = 0; m_si = 0; m_sq = 0; m_ov = 0;
        if (acc) begin
          m_si  = lane_add(0, int'(di));
          m_sq  = lane_add(0, int'(dq));
          m_cnt = 1;
        end
      end else if (m_active && acc) begin
        m_si  = lane_add(m_si, int'(di));
        m_sq  = lane_add(m_sq, int'(dq));
        m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_tvalid", tv, e_tv);
      chk("cmp_busy", busy, m_active);
      chk("cmp_ovf", ovf, e_ovf);
      chk("cmp_acc_i", acc_i, e_ai);
      chk("cmp_acc_q", acc_q, e_aq);
    end
  end

  task automatic step(input bit s, input bit a, input bit b, input int x, input int y);
    start = s; vi = a; vq = b;
    di = IB'(x); dq = QB'(y);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    chk("rst_tvalid", tv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acc_i", acc_i, 0);
    chk("rst_ovf", ovf, 0);

    // Basic: four unit samples, pulse one clock after the fourth
    step(1, 0, 0, 0, 0);
    repeat (4) step(0, 1, 1, 1, 1);
    chk("basic_tvalid", tv, 1);
    chk("basic_acc_i", acc_i, 4);
    chk("basic_acc_q", acc_q, 4);
    idle();
    chk("basic_pulse_len", tv, 0);
    chk("basic_hold", acc_i, 4);

    // Gapped valid
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 3, 1);  idle();
    step(0, 1, 1, -5, 2); idle();
    step(0, 1, 1, 7, 3);  idle(); idle();
    step(0, 1, 1, 2, 4);
    chk("gap_tvalid", tv, 1);
    chk("gap_acc_i", acc_i, 7);
    chk("gap_acc_q", acc_q, 10);
    idle();
    chk("gap_pulse_len", tv, 0);
    chk("gap_hold", acc_i, 7);

    // Mismatched valid is ignored
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1);
    step(0, 1, 1, 1, 1);
    step(0, 1, 0, 50, 50);
    step(0, 1, 1, 1, 1);
    chk("mis_no_pulse", tv, 0);
    step(0, 1, 1, 1, 1);
    chk("mis_tvalid", tv, 1);
    chk("mis_acc_i", acc_i, 4);

    // Back-to-back frames with start on the last sample
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 1, 1, 1, 1);
    step(1, 1, 1, 1, 1);
    chk("b2b_tvalid1", tv, 1);
    chk("b2b_acc_i1", acc_i, 4);
    chk("b2b_busy", busy, 1);
    repeat (4) step(0, 1, 1, 1, 1);
    chk("b2b_tvalid2", tv, 1);
    chk("b2b_acc_i2", acc_i, 4);
    idle();
    chk("b2b_idle", busy, 0);

    // Restart mid-frame
    step(1, 0, 0, 0, 0);
    repeat (2) step(0, 1, 1, 5, 5);
    step(1, 0, 0, 0, 0);
    chk("rst_no_dump", tv, 0);
    repeat (4) step(0, 1, 1, 2, 2);
    chk("restart_tvalid", tv, 1);
    chk("restart_acc_i", acc_i, 8);

    // Reset mid-frame
    step(1, 0, 0, 0, 0);
    repeat (2) step(0, 1, 1, 9, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_acc_i", acc_i, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tvalid", tv, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 1, 1, 1);
    chk("midrst_idle", busy, 0);

    // Overflow
    step(1, 0, 0, 0, 0);
    repeat (4) step(0, 1, 1, 100, -100);
    chk("ovf_tvalid", tv, 1);
`ifdef CPX_ACC_SAT_EN
    chk("ovf_acc_i", acc_i, 127);
    chk("ovf_acc_q", acc_q, -128);
    chk("ovf_flag", ovf, 1);
`else
    chk("ovf_acc_i", acc_i, -112);
    chk("ovf_acc_q", acc_q, 112);
    chk("ovf_flag", ovf, 0);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int x, y;
      bit s, a, b;
      s = ($urandom % 12) == 0;
      a = ($urandom % 4) != 0;
      b = ($urandom % 4) != 0;
      x = (($urandom % 4) == 0) ? int'($urandom_range(0, 255)) - 128
                                : int'($urandom_range(0, 15)) - 8;
      y = (($urandom % 4) == 0) ? int'($urandom_range(0, 255)) - 128
                                : int'($urandom_range(0, 15)) - 8;
      if (($urandom % 500) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      step(s, a, b, x, y);
    end
    repeat (3) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
